ofmap_ddr_packer: RTL and testbench
===================================

OFMAP_DDR_PACKER -- requirements
Module: ofmap_ddr_packer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 144, the MAC output word width (18 x 8-bit channels).
REQ-002 SHALL have parameter OUT_WIDTH, default 256, the DDR write word width.
REQ-003 SHALL have parameter BUF_WIDTH, default 512, the staging buffer capacity in bits.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with ports as follows.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 MAC_data_in  input  IN_WIDTH  conv result word from the ConvUnit.
REQ-008 MAC_data_valid_in  input  1  single-cycle qualifier; there is no backpressure toward the source.
REQ-009 flush_in  input  1  end-of-layer pulse; emit the residual partial word.
REQ-010 DDR_data_out  output  OUT_WIDTH  packed write data.
REQ-011 DDR_valid_out  output  1  DDR_data_out valid.
REQ-012 DDR_ready_in  input  1  the DDR writer accepts the word when valid and ready are both high.
REQ-013 flush_done  output  1  one-cycle pulse when the flush has completed.
REQ-014 overflow  output  1  sticky flag: an input word was dropped.
REQ-015 word_count  output  16  number of DDR words accepted; wraps from 65535 to 0.

Function
REQ-016 The block SHALL keep a BUF_WIDTH staging buffer and a fill count `cnt` (0..BUF_WIDTH); the oldest bits sit at bit 0, and all bits at or above `cnt` are zero.
REQ-017 The output register is "free" when DDR_valid_out=0 or DDR_ready_in=1.
REQ-018 Pop: when registered cnt>=OUT_WIDTH and the output register is free, the block SHALL do three things on the next edge:
- load buf[OUT_WIDTH-1:0] into DDR_data_out and set DDR_valid_out;
- shift the buffer right by OUT_WIDTH, zero-filling the top;
- reduce cnt by OUT_WIDTH.
REQ-019 Push: when MAC_data_valid_in=1 and cnt_after_pop+IN_WIDTH<=BUF_WIDTH, the block SHALL write the word at bit offset cnt_after_pop and add IN_WIDTH to cnt. Push and pop SHALL be allowed in the same cycle.
REQ-020 When a push is refused, the word SHALL be dropped and overflow set to 1 until reset.
REQ-021 While DDR_valid_out=1 and DDR_ready_in=0, DDR_data_out SHALL hold stable.
REQ-022 The first word in SHALL land in bits [IN_WIDTH-1:0] of the first word out. Sixteen 144-bit words SHALL yield exactly nine 256-bit words with no padding.
REQ-023 The state machine SHALL be RUN -> FLUSH on flush_in=1.
REQ-024 In FLUSH, with 0<cnt<OUT_WIDTH and the output register free, the block SHALL emit buf[OUT_WIDTH-1:0] (upper bits zero) and set cnt=0. Full words still drain first, per REQ-018.
REQ-025 In FLUSH, once cnt=0 and DDR_valid_out=0, the block SHALL pulse flush_done for one cycle and return to RUN.
REQ-026 flush_in with cnt=0 and the output empty SHALL give flush_done on the next cycle.
REQ-027 MAC_data_valid_in during FLUSH SHALL be dropped and SHALL set overflow.
REQ-028 flush_in during FLUSH SHALL be ignored.
REQ-029 word_count SHALL increment on each DDR_valid_out && DDR_ready_in.
REQ-030 Latency: DDR_valid_out SHALL rise on the edge after the edge at which registered cnt first reaches >=OUT_WIDTH.

Reset
REQ-031 On rst=1, asynchronously, the following SHALL all be zero:
- buffer, cnt;
- DDR_data_out, DDR_valid_out;
- flush_done, overflow, word_count;
- state=RUN.
REQ-032 Reset mid-burst SHALL discard all buffered data with no further output.

Structure
REQ-033 A shared package SHALL hold IN_WIDTH, OUT_WIDTH, BUF_WIDTH defaults, the count width, and the RUN/FLUSH state enumeration.
REQ-034 The output holding register with valid/ready SHALL be one sub-module, ddr_out_reg. Buffer, count, and FSM stay in the parent.

Verification
REQ-035 Scenario 1: 16 back-to-back words, ready=1 throughout -> 9 output words equal to the 2304-bit concatenation, cnt=0, word_count=9, overflow=0.
REQ-036 Scenario 2: 3 words, then flush_in -> 2 output words; the second has bits [175:0] = residual and [255:176] = 0; flush_done pulses once; word_count=2.
REQ-037 Scenario 3: ready=0 throughout, with continuous valid from cnt=0 ->
- words 1-5 are accepted;
- word 6 is dropped and overflow=1;
- DDR_data_out holds word 0's bits unchanged;
- releasing ready drains the remainder in order.
REQ-038 Scenario 4: flush_in with an empty buffer -> no output word and flush_done one cycle later. A valid during FLUSH -> overflow=1.
REQ-039 Scenario 5: assert rst while DDR_valid_out=1 and cnt=176 -> all outputs zero immediately. After release, 16 words give a clean 9-word result.
REQ-040 Scenario 6: 65536 accepted words -> word_count wraps to 0.

Source files
------------

// File: rtl/ofmap_ddr_packer_pkg.sv
// Shared defaults, count width and FSM state encoding for the ofmap DDR packer.
package ofmap_ddr_packer_pkg;

  localparam int IN_WIDTH_DEF  = 144;
  localparam int OUT_WIDTH_DEF = 256;
  localparam int BUF_WIDTH_DEF = 512;

  // Fill count must represent 0..BUF_WIDTH inclusive.
  localparam int CNT_W_DEF = $clog2(BUF_WIDTH_DEF + 1);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } packer_state_e;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

endpackage

// File: rtl/ofmap_ddr_packer_if.sv
// Input word stream and DDR write-side handshake for the ofmap packer.
interface ofmap_ddr_packer_if
  import ofmap_ddr_packer_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF
);
  // Handshake: MAC_data_valid_in is a one-cycle qualifier with no backpressure;
  // a DDR word transfers on any rising edge where DDR_valid_out && DDR_ready_in,
  // and DDR_data_out is held stable while DDR_valid_out=1 and DDR_ready_in=0.
  logic [IN_WIDTH-1:0]  MAC_data_in;
  logic                 MAC_data_valid_in;
  logic                 flush_in;
  logic [OUT_WIDTH-1:0] DDR_data_out;
  logic                 DDR_valid_out;
  logic                 DDR_ready_in;

  modport master (
    output MAC_data_in, MAC_data_valid_in, flush_in, DDR_ready_in,
    input  DDR_data_out, DDR_valid_out
  );

  modport slave (
    input  MAC_data_in, MAC_data_valid_in, flush_in, DDR_ready_in,
    output DDR_data_out, DDR_valid_out
  );

endinterface

// File: rtl/ofmap_ddr_packer_ddr_out_reg.sv
// Single-entry valid/ready output holding register feeding the DDR writer.
module ddr_out_reg #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             free,
  output logic             accept
);

  assign free   = !valid || ready;
  assign accept = valid && ready;

  // The parent only asserts load while free, so data never changes during a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ofmap_ddr_packer.sv
// Packs IN_WIDTH conv result words into OUT_WIDTH DDR words through a
// BUF_WIDTH staging buffer, with an end-of-layer flush of the partial word.
module ofmap_ddr_packer
  import ofmap_ddr_packer_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF,
  parameter int BUF_WIDTH = BUF_WIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  ofmap_ddr_packer_if.slave              bus,
  output logic                           flush_done,
  output logic                           overflow,
  output logic [15:0]                    word_count,
  output logic [0:0]                     state_dbg,
  output logic [$clog2(BUF_WIDTH+1)-1:0] cnt_dbg
);

  localparam int CW = $clog2(BUF_WIDTH + 1);
  localparam logic [CW-1:0] OUT_C  = CW'(OUT_WIDTH);
  localparam logic [CW:0]   IN_C1  = (CW+1)'(IN_WIDTH);
  localparam logic [CW:0]   BUF_C1 = (CW+1)'(BUF_WIDTH);

  logic [BUF_WIDTH-1:0] buf_q, buf_after_pop, buf_next;
  logic [CW-1:0]        cnt_q, cnt_after_pop, cnt_next;
  logic [CW:0]          fill_sum;
  logic [0:0]           state_q;
  logic                 out_free, out_accept;
  logic                 pop_full, pop_part, load, push_ok;

  ddr_out_reg #(.WIDTH(OUT_WIDTH)) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (buf_q[OUT_WIDTH-1:0]),
    .ready     (bus.DDR_ready_in),
    .data      (bus.DDR_data_out),
    .valid     (bus.DDR_valid_out),
    .free      (out_free),
    .accept    (out_accept)
  );

  // A partial pop only happens while flushing; bits above cnt are already zero.
  assign pop_full = (cnt_q >= OUT_C) && out_free;
  assign pop_part = (state_q == ST_FLUSH) && (cnt_q != '0) && (cnt_q < OUT_C) && out_free;
  assign load     = pop_full || pop_part;

  always_comb begin
    buf_after_pop = buf_q;
    cnt_after_pop = cnt_q;
    if (pop_full) begin
      buf_after_pop = buf_q >> OUT_WIDTH;
      cnt_after_pop = cnt_q - OUT_C;
    end else if (pop_part) begin
      buf_after_pop = '0;
      cnt_after_pop = '0;
    end

    fill_sum = {1'b0, cnt_after_pop} + IN_C1;
    push_ok  = bus.MAC_data_valid_in && (state_q == ST_RUN) && (fill_sum <= BUF_C1);

    buf_next = buf_after_pop;
    cnt_next = cnt_after_pop;
    if (push_ok) begin
      buf_next = buf_after_pop | (BUF_WIDTH'(bus.MAC_data_in) << cnt_after_pop);
      cnt_next = fill_sum[CW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q      <= '0;
      cnt_q      <= '0;
      state_q    <= ST_RUN;
      flush_done <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      buf_q      <= buf_next;
      cnt_q      <= cnt_next;
      flush_done <= 1'b0;
      if (bus.MAC_data_valid_in && !push_ok) begin
        overflow <= 1'b1;
      end
      if (out_accept) begin
        word_count <= word_count + 16'd1;
      end
      case (state_q)
        ST_RUN: begin
          if (bus.flush_in) begin
            state_q <= ST_FLUSH;
          end
        end
        default: begin
          // Done only once the buffer is empty and the last word has left.
          if ((cnt_q == '0) && !bus.DDR_valid_out) begin
            flush_done <= 1'b1;
            state_q    <= ST_RUN;
          end
        end
      endcase
    end
  end

  assign state_dbg = state_q;
  assign cnt_dbg   = cnt_q;

endmodule

// File: tb/tb_ofmap_ddr_packer.sv
// Scoreboard bench for ofmap_ddr_packer: directed scenarios, bit-stream model, negedge monitor.
module tb_ofmap_ddr_packer;
  import ofmap_ddr_packer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ofmap_ddr_packer_if #(.IN_WIDTH(144), .OUT_WIDTH(256)) bus ();
  logic        flush_done, overflow;
  logic [15:0] word_count;
  logic [0:0]  state_dbg;
  logic [9:0]  cnt_dbg;

  ofmap_ddr_packer #(.IN_WIDTH(144), .OUT_WIDTH(256), .BUF_WIDTH(512)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .flush_done (flush_done),
    .overflow   (overflow),
    .word_count (word_count),
    .state_dbg  (state_dbg),
    .cnt_dbg    (cnt_dbg)
  );

  // Narrow instance: one DDR word per cycle, used for the word_count wrap.
  ofmap_ddr_packer_if #(.IN_WIDTH(8), .OUT_WIDTH(8)) bus2 ();
  logic        flush_done2, overflow2;
  logic [15:0] word_count2;
  logic [0:0]  state_dbg2;
  logic [4:0]  cnt_dbg2;

  ofmap_ddr_packer #(.IN_WIDTH(8), .OUT_WIDTH(8), .BUF_WIDTH(16)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus2),
    .flush_done (flush_done2),
    .overflow   (overflow2),
    .word_count (word_count2),
    .state_dbg  (state_dbg2),
    .cnt_dbg    (cnt_dbg2)
  );

  // ---------------- scoreboard state ----------------
  int           checks = 0;
  int           failures = 0;
  int           flush_pulses = 0;
  logic [255:0] exp_q[$];
  logic [1023:0] m_bits;
  int           m_cnt;
  logic         stall_prev = 1'b0;
  logic [255:0] held_data;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference bit stream: oldest bit at position 0, full words retired to exp_q.
  task automatic model_push(input logic [143:0] w);
    logic [1023:0] ext;
    ext = '0;
    ext[143:0] = w;
    m_bits = m_bits | (ext << m_cnt);
    m_cnt += 144;
    while (m_cnt >= 256) begin
      exp_q.push_back(m_bits[255:0]);
      m_bits = m_bits >> 256;
      m_cnt -= 256;
    end
  endtask

  task automatic model_flush();
    if (m_cnt > 0) begin
      exp_q.push_back(m_bits[255:0]);
      m_bits = '0;
      m_cnt = 0;
    end
  endtask

  function automatic logic [143:0] mk_word(input int k);
    logic [143:0] w;
    for (int ch = 0; ch < 18; ch++) w[ch*8 +: 8] = 8'(k * 18 + ch + 1);
    return w;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (flush_done) flush_pulses++;
      if (stall_prev && bus.DDR_valid_out) check("hold_stable", bus.DDR_data_out, held_data);
      if (bus.DDR_valid_out && bus.DDR_ready_in) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%h expected=none", bus.DDR_data_out);
        end else begin
          check("ddr_word", bus.DDR_data_out, exp_q.pop_front());
        end
      end
      stall_prev = bus.DDR_valid_out && !bus.DDR_ready_in;
      held_data  = bus.DDR_data_out;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.MAC_data_in = '0;
    bus.MAC_data_valid_in = 1'b0;
    bus.flush_in = 1'b0;
    bus.DDR_ready_in = 1'b0;
    bus2.MAC_data_in = 8'h5a;
    bus2.MAC_data_valid_in = 1'b0;
    bus2.flush_in = 1'b0;
    bus2.DDR_ready_in = 1'b1;
    exp_q.delete();
    m_bits = '0;
    m_cnt = 0;
    tick();
    tick();
    rst = 1'b0;
    flush_pulses = 0;
    tick();
  endtask

  task automatic send(input logic [143:0] w, input bit exp_acc);
    bus.MAC_data_in = w;
    bus.MAC_data_valid_in = 1'b1;
    if (exp_acc) model_push(w);
    tick();
    bus.MAC_data_valid_in = 1'b0;
  endtask

  task automatic pulse_flush();
    bus.flush_in = 1'b1;
    model_flush();
    tick();
    bus.flush_in = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bus.DDR_valid_out) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_timeout actual=pending:%0d expected=pending:0", name, exp_q.size());
    end
  endtask

  task automatic wait_flush_done(input string name, input int budget);
    int n = 0;
    while (!flush_done && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_timeout actual=flush_done:0 expected=flush_done:1", name);
    end
  endtask

  // ---------------- scenarios ----------------
  initial begin
    do_reset();
    check("reset_valid", 256'(bus.DDR_valid_out), 256'(0));
    check("reset_data", bus.DDR_data_out, 256'(0));
    check("reset_cnt", 256'(cnt_dbg), 256'(0));
    check("reset_word_count", 256'(word_count), 256'(0));
    check("reset_state", 256'(state_dbg), 256'(ST_RUN));

    // Scenario 1: 16 words, ready high, exact 9-word result
    bus.DDR_ready_in = 1'b1;
    for (int k = 0; k < 16; k++) begin
      send(mk_word(k), 1'b1);
      if (k == 1) check("s1_valid_before_latency", 256'(bus.DDR_valid_out), 256'(0));
      if (k == 2) check("s1_valid_after_latency", 256'(bus.DDR_valid_out), 256'(1));
    end
    wait_idle("s1", 50);
    check("s1_cnt", 256'(cnt_dbg), 256'(0));
    check("s1_word_count", 256'(word_count), 256'(9));
    check("s1_overflow", 256'(overflow), 256'(0));

    // Scenario 2: 3 words then flush, residual 176 bits zero-padded
    do_reset();
    bus.DDR_ready_in = 1'b1;
    for (int k = 0; k < 3; k++) send(mk_word(20 + k), 1'b1);
    pulse_flush();
    wait_flush_done("s2_flush", 40);
    wait_idle("s2", 40);
    tick();
    check("s2_flush_pulses", 256'(flush_pulses), 256'(1));
    check("s2_word_count", 256'(word_count), 256'(2));
    check("s2_cnt", 256'(cnt_dbg), 256'(0));
    check("s2_state", 256'(state_dbg), 256'(ST_RUN));

    // Scenario 3: ready low, 5 accepted, 6th dropped, output held
    do_reset();
    bus.DDR_ready_in = 1'b0;
    for (int k = 0; k < 5; k++) send(mk_word(40 + k), 1'b1);
    check("s3_overflow_before", 256'(overflow), 256'(0));
    send(mk_word(45), 1'b0);
    check("s3_overflow", 256'(overflow), 256'(1));
    check("s3_cnt", 256'(cnt_dbg), 256'(464));
    check("s3_valid", 256'(bus.DDR_valid_out), 256'(1));
    if (exp_q.size() > 0) check("s3_held_word0", bus.DDR_data_out, exp_q[0]);
    repeat (4) tick();
    bus.DDR_ready_in = 1'b1;
    pulse_flush();
    wait_flush_done("s3_flush", 40);
    wait_idle("s3", 40);
    check("s3_word_count", 256'(word_count), 256'(3));
    check("s3_cnt_end", 256'(cnt_dbg), 256'(0));

    // Scenario 4: flush on empty buffer, valid during FLUSH dropped
    do_reset();
    bus.DDR_ready_in = 1'b1;
    pulse_flush();
    check("s4_done_not_yet", 256'(flush_done), 256'(0));
    check("s4_state_flush", 256'(state_dbg), 256'(ST_FLUSH));
    bus.MAC_data_in = mk_word(99);
    bus.MAC_data_valid_in = 1'b1;
    tick();
    bus.MAC_data_valid_in = 1'b0;
    check("s4_flush_done", 256'(flush_done), 256'(1));
    check("s4_overflow", 256'(overflow), 256'(1));
    check("s4_no_output", 256'(bus.DDR_valid_out), 256'(0));
    tick();
    check("s4_done_one_cycle", 256'(flush_done), 256'(0));
    check("s4_state_run", 256'(state_dbg), 256'(ST_RUN));
    check("s4_flush_pulses", 256'(flush_pulses), 256'(1));

    // Scenario 5: reset mid-burst, then a clean 16-word run
    do_reset();
    bus.DDR_ready_in = 1'b0;
    for (int k = 0; k < 3; k++) send(mk_word(60 + k), 1'b1);
    check("s5_pre_valid", 256'(bus.DDR_valid_out), 256'(1));
    check("s5_pre_cnt", 256'(cnt_dbg), 256'(176));
    #2 rst = 1'b1;
    #1;
    check("s5_rst_valid", 256'(bus.DDR_valid_out), 256'(0));
    check("s5_rst_data", bus.DDR_data_out, 256'(0));
    check("s5_rst_cnt", 256'(cnt_dbg), 256'(0));
    check("s5_rst_word_count", 256'(word_count), 256'(0));
    check("s5_rst_flags", {254'(0), flush_done, overflow}, 256'(0));
    exp_q.delete();
    m_bits = '0;
    m_cnt = 0;
    tick();
    rst = 1'b0;
    bus.DDR_ready_in = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) send(mk_word(80 + k), 1'b1);
    wait_idle("s5", 50);
    check("s5_word_count", 256'(word_count), 256'(9));
    check("s5_cnt", 256'(cnt_dbg), 256'(0));

    // Scenario 6: word_count wrap on the narrow instance
    do_reset();
    bus2.MAC_data_valid_in = 1'b1;
    repeat (65535) tick();
    bus2.MAC_data_valid_in = 1'b0;
    repeat (4) tick();
    check("s6_count_65535", 256'(word_count2), 256'(65535));
    bus2.MAC_data_valid_in = 1'b1;
    tick();
    bus2.MAC_data_valid_in = 1'b0;
    repeat (4) tick();
    check("s6_count_wrap", 256'(word_count2), 256'(0));
    check("s6_overflow", 256'(overflow2), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
